// File: rtl/serial_a_paralelo_sync_pkg.sv
// Shared symbols and state encoding for the serial receive/alignment block.
// COM and IDLE must match the values used by the parallel-to-serial transmitter.
package serial_a_paralelo_sync_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PHASE_W = 3;

    localparam logic [BYTE_W-1:0] COM  = 8'hBC;
    localparam logic [BYTE_W-1:0] IDLE = 8'h7C;

    typedef enum logic [1:0] {
        UNALIGNED = 2'd0,
        ALIGNING  = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    // Payload is anything that is neither a comma nor filler.
    function automatic logic is_payload(input logic [BYTE_W-1:0] b);
        return (b != COM) && (b != IDLE);
    endfunction

endpackage

// File: rtl/serial_a_paralelo_sync_if.sv
// Serial input and deserialized byte outputs of the receive aligner.
// master is the aligner's view; slave is the serial source / byte consumer.
interface serial_a_paralelo_sync_if;
    import serial_a_paralelo_sync_pkg::*;

    logic              in;
    logic [BYTE_W-1:0] data_out;
    logic              byte_strobe;
    logic              valid_out;
    logic              active;

    modport master (
        input  in,
        output data_out,
        output byte_strobe,
        output valid_out,
        output active
    );

    modport slave (
        output in,
        input  data_out,
        input  byte_strobe,
        input  valid_out,
        input  active
    );

endinterface

// File: rtl/serial_shift8.sv
// Serial shift register and mod-8 bit counter; realign forces the counter to
// zero so the next boundary falls eight edges after the realigning edge.
module serial_shift8
    import serial_a_paralelo_sync_pkg::*;
(
    input  logic              clk32f,
    input  logic              reset,
    input  logic              in,
    input  logic              realign,
    output logic [BYTE_W-1:0] cand_c,
    output logic              boundary_c
);

    // Only the seven most recent bits are kept; the oldest bit of an 8-bit
    // history would never reach the candidate byte.
    logic [BYTE_W-2:0]  sr;
    logic [PHASE_W-1:0] bit_cnt;

    always_ff @(posedge clk32f) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            sr      <= {sr[BYTE_W-3:0], in};
            bit_cnt <= realign ? '0 : bit_cnt + PHASE_W'(1);
        end
    end

    assign cand_c     = {sr, in};
    assign boundary_c = (bit_cnt == PHASE_W'(7));

endmodule

// File: rtl/serial_a_paralelo_sync.sv
// Receive aligner: locks byte alignment on a run of COM_COUNT aligned COMs,
// then emits every deserialized byte with a strobe and a payload flag.
module serial_a_paralelo_sync
    import serial_a_paralelo_sync_pkg::*;
#(
    parameter int unsigned COM_COUNT = 4
) (
    input  logic                         clk32f,
    input  logic                         reset,
    serial_a_paralelo_sync_if.master     bus
);

    localparam logic [CNT_W-1:0] LAST_COM = CNT_W'(COM_COUNT - 1);

    state_t            state;
    logic [CNT_W-1:0]  com_cnt;
    logic [BYTE_W-1:0] cand_c;
    logic              boundary_c;
    logic              realign_c;
    logic              is_com_c;

    logic [BYTE_W-1:0] data_out_r;
    logic              byte_strobe_r;
    logic              valid_out_r;
    logic              active_r;

    assign is_com_c  = (cand_c == COM);
    // Bit-by-bit search: any COM seen while unaligned defines the byte phase.
    assign realign_c = (state == UNALIGNED) && is_com_c;

    serial_shift8 u_shift8 (
        .clk32f     (clk32f),
        .reset      (reset),
        .in         (bus.in),
        .realign    (realign_c),
        .cand_c     (cand_c),
        .boundary_c (boundary_c)
    );

    always_ff @(posedge clk32f) begin
        if (reset) begin
            state         <= UNALIGNED;
            com_cnt       <= '0;
            data_out_r    <= '0;
            byte_strobe_r <= 1'b0;
            valid_out_r   <= 1'b0;
            active_r      <= 1'b0;
        end else begin
            byte_strobe_r <= 1'b0;
            case (state)
                UNALIGNED: begin
                    if (is_com_c) begin
                        com_cnt <= CNT_W'(1);
                        state   <= ALIGNING;
                    end
                end
                ALIGNING: begin
                    // A single non-COM at a boundary discards the whole run.
                    if (boundary_c) begin
                        if (is_com_c && com_cnt == LAST_COM) begin
                            com_cnt  <= '0;
                            active_r <= 1'b1;
                            state    <= ACTIVE;
                        end else if (is_com_c) begin
                            com_cnt <= com_cnt + CNT_W'(1);
                        end else begin
                            com_cnt <= '0;
                            state   <= UNALIGNED;
                        end
                    end
                end
                ACTIVE: begin
                    // No loss-of-sync detection: only reset leaves this state.
                    if (boundary_c) begin
                        data_out_r    <= cand_c;
                        byte_strobe_r <= 1'b1;
                        valid_out_r   <= is_payload(cand_c);
                    end
                end
                default: begin
                    state   <= UNALIGNED;
                    com_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.data_out    = data_out_r;
    assign bus.byte_strobe = byte_strobe_r;
    assign bus.valid_out   = valid_out_r;
    assign bus.active      = active_r;

endmodule

// File: tb/tb_serial_a_paralelo_sync.sv
// Directed bench for serial_a_paralelo_sync: a bit-stream model predicts every
// cycle's outputs, and literal expectations pin the key alignment events.
module tb_serial_a_paralelo_sync;
    import serial_a_paralelo_sync_pkg::*;

    localparam int unsigned NCOM = 4;

    logic clk32f = 1'b0;
    logic reset  = 1'b1;

    serial_a_paralelo_sync_if bus ();

    serial_a_paralelo_sync #(.COM_COUNT(NCOM)) dut (
        .clk32f (clk32f),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk32f = ~clk32f;

    int vectors     = 0;
    int miscompares = 0;

    // Model: history window, edge index since reset, and the edge index of the
    // COM that fixed the byte phase; boundaries are multiples of 8 from it.
    logic [7:0] m_win;
    int         m_mode;
    int         m_k;
    int         m_anchor;
    int         m_coms;
    logic [7:0] m_data;
    logic       m_strobe;
    logic       m_valid;
    logic       m_active;
    bit         m_live = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic b, input logic rst);
        if (rst) begin
            m_win = 8'h00; m_mode = 0; m_k = 0; m_anchor = 0; m_coms = 0;
            m_data = 8'h00; m_strobe = 1'b0; m_valid = 1'b0; m_active = 1'b0;
        end else begin
            m_win    = {m_win[6:0], b};
            m_strobe = 1'b0;
            if (m_mode == 0) begin
                if (m_win == 8'hBC) begin
                    m_mode = 1; m_anchor = m_k; m_coms = 1;
                end
            end else if ((m_k - m_anchor) % 8 == 0) begin
                if (m_mode == 1) begin
                    if (m_win == 8'hBC) begin
                        m_coms++;
                        if (m_coms == NCOM) begin
                            m_mode = 2; m_active = 1'b1;
                        end
                    end else begin
                        m_mode = 0;
                    end
                end else begin
                    m_data   = m_win;
                    m_strobe = 1'b1;
                    m_valid  = (m_win != 8'hBC) && (m_win != 8'h7C);
                end
            end
            m_k++;
        end
    endtask

    // One clock edge: drive, let the edge happen, advance the model, settle.
    task automatic tick(input logic b, input logic rst);
        bus.in = b;
        reset  = rst;
        @(posedge clk32f);
        model_step(b, rst);
        m_live = 1'b1;
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) tick(b[7-i], 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'($urandom_range(0, 1)), 1'b1);
            check("rst_data", bus.data_out, 8'h00);
            check("rst_strobe", {7'd0, bus.byte_strobe}, 8'h00);
            check("rst_valid", {7'd0, bus.valid_out}, 8'h00);
            check("rst_active", {7'd0, bus.active}, 8'h00);
        end
    endtask

    task automatic expect_byte(input string name, input logic [7:0] d, input logic v);
        check({name, "_data"}, bus.data_out, d);
        check({name, "_valid"}, {7'd0, bus.valid_out}, {7'd0, v});
        check({name, "_strobe"}, {7'd0, bus.byte_strobe}, 8'h01);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk32f) begin
        if (m_live) begin
            check("m_data", bus.data_out, m_data);
            check("m_strobe", {7'd0, bus.byte_strobe}, {7'd0, m_strobe});
            check("m_valid", {7'd0, bus.valid_out}, {7'd0, m_valid});
            check("m_active", {7'd0, bus.active}, {7'd0, m_active});
        end
    end

    initial begin
        bus.in = 1'b0;

        // Offset 0: active on the last bit of the 4th COM, then 7C and A5.
        do_reset();
        tick(1'b0, 1'b0);
        check("post_rst_active", {7'd0, bus.active}, 8'h00);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        send_bits(8'hBC, 7);
        check("off0_not_yet", {7'd0, bus.active}, 8'h00);
        tick(1'b0, 1'b0);
        check("off0_active", {7'd0, bus.active}, 8'h01);
        check("off0_no_strobe", {7'd0, bus.byte_strobe}, 8'h00);
        send_byte(8'h7C);
        expect_byte("off0_idle", 8'h7C, 1'b0);
        send_byte(8'hA5);
        expect_byte("off0_pay", 8'hA5, 1'b1);

        // Arbitrary offset: three random prefix bits.
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        check("offs_active", {7'd0, bus.active}, 8'h01);
        send_byte(8'h12);
        expect_byte("offs_12", 8'h12, 1'b1);
        send_byte(8'h34);
        expect_byte("offs_34", 8'h34, 1'b1);
        tick(1'b0, 1'b0);
        check("offs_hold", bus.data_out, 8'h34);
        check("offs_strobe_low", {7'd0, bus.byte_strobe}, 8'h00);

        // Broken COM run: the first three COMs must not count.
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        send_byte(8'h00);
        check("brk_after00", {7'd0, bus.active}, 8'h00);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("brk_3rd", {7'd0, bus.active}, 8'h00);
        send_byte(8'hBC);
        check("brk_active", {7'd0, bus.active}, 8'h01);
        send_byte(8'h7C);
        expect_byte("brk_idle", 8'h7C, 1'b0);

        // Straddling false COM in 0B C0 must self-correct.
        do_reset();
        send_byte(8'h0B);
        send_byte(8'hC0);
        check("strd_after", {7'd0, bus.active}, 8'h00);
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("strd_3rd", {7'd0, bus.active}, 8'h00);
        send_byte(8'hBC);
        check("strd_active", {7'd0, bus.active}, 8'h01);

        // Reset mid-ACTIVE, then a payload byte before a new COM run.
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        send_byte(8'h5A);
        expect_byte("mid_5a", 8'h5A, 1'b1);
        send_bits(8'h66, 3);
        tick(1'b0, 1'b1);
        check("mid_rst_data", bus.data_out, 8'h00);
        check("mid_rst_valid", {7'd0, bus.valid_out}, 8'h00);
        check("mid_rst_active", {7'd0, bus.active}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick(i[0] ? 1'b1 : 1'b0, 1'b0);
            check("mid_no_strobe", {7'd0, bus.byte_strobe}, 8'h00);
        end
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        check("mid_realign", {7'd0, bus.active}, 8'h01);
        send_byte(8'h9A);
        expect_byte("mid_9a", 8'h9A, 1'b1);

        @(negedge clk32f);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
